// File: rtl/timer_pkg.sv
// Shared constants and BCD helpers for the mm:ss countdown timer.
package timer_pkg;

   // FSM state encoding
   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] RUN    = 2'd1;
   localparam logic [1:0] PAUSED = 2'd2;
   localparam logic [1:0] DONE   = 2'd3;

   // BCD digit limits
   localparam logic [3:0] SEC_TENS_MAX = 4'd5;
   localparam logic [3:0] DIGIT_MAX    = 4'd9;

   // Limit a single BCD digit to a maximum value
   function automatic logic [3:0] clamp_digit(input logic [3:0] digit, input logic [3:0] max_val);
      return (digit > max_val) ? max_val : digit;
   endfunction

   // Decrement a {min_tens, min_ones, sec_tens, sec_ones} count by one second; 00:00 stays put
   function automatic logic [15:0] bcd_decrement(input logic [15:0] count);
      logic [3:0] min_t, min_o, sec_t, sec_o;
      {min_t, min_o, sec_t, sec_o} = count;
      if (count == 16'h0000) begin
         return 16'h0000;
      end
      if (sec_o != 4'd0) begin
         sec_o = sec_o - 4'd1;
      end else begin
         sec_o = DIGIT_MAX;
         if (sec_t != 4'd0) begin
            sec_t = sec_t - 4'd1;
         end else begin
            sec_t = SEC_TENS_MAX;
            if (min_o != 4'd0) begin
               min_o = min_o - 4'd1;
            end else begin
               min_o = DIGIT_MAX;
               min_t = min_t - 4'd1;
            end
         end
      end
      return {min_t, min_o, sec_t, sec_o};
   endfunction

endpackage

// File: rtl/countdown_timer_if.sv
// Control and display bus of the countdown timer.
interface countdown_timer_if;
   logic       load;
   logic [7:0] load_min;
   logic [7:0] load_sec;
   logic       start;
   logic       pause;
   logic [7:0] min_bcd;
   logic [7:0] sec_bcd;
   logic       running;
   logic       done;
   logic       done_pulse;

   modport master (
      output load, load_min, load_sec, start, pause,
      input  min_bcd, sec_bcd, running, done, done_pulse
   );

   modport slave (
      input  load, load_min, load_sec, start, pause,
      output min_bcd, sec_bcd, running, done, done_pulse
   );
endinterface

// File: rtl/countdown_timer_tick_sync.sv
// Synchronises an asynchronous level and turns its rising edge into a one-cycle tick.
module tick_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk_in,
   input  logic rst_n,
   input  logic async_in,
   output logic tick_out
);

   logic [SYNC_STAGES-1:0] sync_d, sync_q;
   logic                   prev_d, prev_q;

   // Shift the input through the synchroniser and remember the last synchronised value
   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
      prev_d = sync_q[SYNC_STAGES-1];
   end

   // Synchroniser and edge-detect flops
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= sync_d;
         prev_q <= prev_d;
      end
   end

   assign tick_out = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/countdown_timer.sv
// mm:ss BCD countdown driven by the slow clock from clock_divider.
module countdown_timer
   import timer_pkg::*;
#(
   parameter int SYNC_STAGES    = 2,
   parameter int TICKS_PER_STEP = 1
) (
   input  logic               clk_in,
   input  logic               rst_n,
   input  logic               slow_clk,
   countdown_timer_if.slave   bus
);

   localparam logic [7:0] PRESC_LAST = 8'(TICKS_PER_STEP - 1);

   logic        tick;
   logic [1:0]  state_d, state_q;
   logic [7:0]  min_d, min_q;
   logic [7:0]  sec_d, sec_q;
   logic [7:0]  presc_d, presc_q;
   logic        running_d, running_q;
   logic        done_d, done_q;
   logic        done_pulse_d, done_pulse_q;
   logic [15:0] load_count;
   logic [15:0] dec_count;

   tick_sync #(.SYNC_STAGES(SYNC_STAGES)) u_tick_sync (
      .clk_in   (clk_in),
      .rst_n    (rst_n),
      .async_in (slow_clk),
      .tick_out (tick)
   );

   // Clamp the requested load value to a legal 99:59-limited BCD count
   always_comb begin
      load_count = {clamp_digit(bus.load_min[7:4], DIGIT_MAX),
                    clamp_digit(bus.load_min[3:0], DIGIT_MAX),
                    clamp_digit(bus.load_sec[7:4], SEC_TENS_MAX),
                    clamp_digit(bus.load_sec[3:0], DIGIT_MAX)};
      dec_count  = bcd_decrement({min_q, sec_q});
   end

   // Next-state logic: load overrides everything, then the FSM, prescaler and BCD count
   always_comb begin
      state_d      = state_q;
      min_d        = min_q;
      sec_d        = sec_q;
      presc_d      = presc_q;
      done_pulse_d = 1'b0;
      if (bus.load) begin
         state_d = IDLE;
         {min_d, sec_d} = load_count;
         presc_d = 8'd0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.start && ({min_q, sec_q} != 16'h0000)) begin
                  state_d = RUN;
                  presc_d = 8'd0;
               end
            end
            RUN: begin
               if (bus.pause) begin
                  state_d = PAUSED;
               end else if (tick) begin
                  if (presc_q == PRESC_LAST) begin
                     presc_d = 8'd0;
                     if ({min_q, sec_q} == 16'h0001) begin
                        state_d        = DONE;
                        {min_d, sec_d} = 16'h0000;
                        done_pulse_d   = 1'b1;
                     end else begin
                        {min_d, sec_d} = dec_count;
                     end
                  end else begin
                     presc_d = presc_q + 8'd1;
                  end
               end
            end
            PAUSED: begin
               if (bus.start) begin
                  state_d = RUN;
               end
            end
            DONE: begin
               state_d = DONE;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
      running_d = (state_d == RUN);
      done_d    = (state_d == DONE);
   end

   // State, count and registered status outputs
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         min_q        <= 8'h00;
         sec_q        <= 8'h00;
         presc_q      <= 8'd0;
         running_q    <= 1'b0;
         done_q       <= 1'b0;
         done_pulse_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         min_q        <= min_d;
         sec_q        <= sec_d;
         presc_q      <= presc_d;
         running_q    <= running_d;
         done_q       <= done_d;
         done_pulse_q <= done_pulse_d;
      end
   end

   assign bus.min_bcd    = min_q;
   assign bus.sec_bcd    = sec_q;
   assign bus.running    = running_q;
   assign bus.done       = done_q;
   assign bus.done_pulse = done_pulse_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer: one instance stepping every tick, one every fourth tick.
module tb_countdown_timer;

   logic clk_in;
   logic rst_n;
   logic slow_clk;
   logic slow_clk4;

   countdown_timer_if bus1 ();
   countdown_timer_if bus4 ();

   countdown_timer #(.SYNC_STAGES(2), .TICKS_PER_STEP(1)) dut (
      .clk_in   (clk_in),
      .rst_n    (rst_n),
      .slow_clk (slow_clk),
      .bus      (bus1)
   );

   countdown_timer #(.SYNC_STAGES(2), .TICKS_PER_STEP(4)) dut4 (
      .clk_in   (clk_in),
      .rst_n    (rst_n),
      .slow_clk (slow_clk4),
      .bus      (bus4)
   );

   typedef struct {
      string       tag;
      int          inst;
      logic [18:0] val;
   } exp_t;

   exp_t sb_q[$];
   int   vector_count;
   int   miscompare_count;

   // Free-running system clock
   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   // Hard stop in case something stalls
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Single comparison point: counts and reports
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vector_count++;
      if (observed !== expected) begin
         miscompare_count++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   // Packed view of one instance's outputs {min, sec, running, done, done_pulse}
   function automatic logic [18:0] observe(input int inst);
      if (inst == 1)
         return {bus1.min_bcd, bus1.sec_bcd, bus1.running, bus1.done, bus1.done_pulse};
      else
         return {bus4.min_bcd, bus4.sec_bcd, bus4.running, bus4.done, bus4.done_pulse};
   endfunction

   task automatic pushExpect(input string tag, input int inst, input logic [7:0] mn, input logic [7:0] sc,
                             input logic run, input logic dn, input logic dp);
      exp_t e;
      e.tag  = tag;
      e.inst = inst;
      e.val  = {mn, sc, run, dn, dp};
      sb_q.push_back(e);
   endtask

   task automatic popCompare();
      exp_t e;
      if (sb_q.size() == 0) begin
         checkOutput("sb_underflow", 32'd1, 32'd0);
      end else begin
         e = sb_q.pop_front();
         checkOutput(e.tag, {13'd0, observe(e.inst)}, {13'd0, e.val});
      end
   endtask

   // Drive one-cycle strobes at a falling edge; called and returns at a falling edge
   task automatic applyStimulus(input int inst, input logic ld, input logic [7:0] mn, input logic [7:0] sc,
                                input logic st, input logic ps);
      if (inst == 1) begin
         bus1.load = ld; bus1.load_min = mn; bus1.load_sec = sc; bus1.start = st; bus1.pause = ps;
      end else begin
         bus4.load = ld; bus4.load_min = mn; bus4.load_sec = sc; bus4.start = st; bus4.pause = ps;
      end
      @(negedge clk_in);
      if (inst == 1) begin
         bus1.load = 1'b0; bus1.start = 1'b0; bus1.pause = 1'b0;
      end else begin
         bus4.load = 1'b0; bus4.start = 1'b0; bus4.pause = 1'b0;
      end
   endtask

   // One slow_clk period: high long enough for the tick to land, then low to re-arm
   task automatic tickSlow(input int inst);
      if (inst == 1) slow_clk = 1'b1; else slow_clk4 = 1'b1;
      repeat (4) @(negedge clk_in);
      if (inst == 1) slow_clk = 1'b0; else slow_clk4 = 1'b0;
      repeat (3) @(negedge clk_in);
   endtask

   initial begin
      int pulses;
      int seen_done;

      vector_count     = 0;
      miscompare_count = 0;
      rst_n     = 1'b0;
      slow_clk  = 1'b0;
      slow_clk4 = 1'b0;
      bus1.load = 1'b0; bus1.load_min = 8'h00; bus1.load_sec = 8'h00; bus1.start = 1'b0; bus1.pause = 1'b0;
      bus4.load = 1'b0; bus4.load_min = 8'h00; bus4.load_sec = 8'h00; bus4.start = 1'b0; bus4.pause = 1'b0;

      // Reset values
      repeat (3) @(negedge clk_in);
      pushExpect("reset_dut1", 1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
      pushExpect("reset_dut4", 4, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
      popCompare();
      popCompare();
      rst_n = 1'b1;
      @(negedge clk_in);

      // Reset asserted while running at 12:34
      applyStimulus(1, 1'b1, 8'h12, 8'h34, 1'b0, 1'b0);
      pushExpect("load_12_34", 1, 8'h12, 8'h34, 1'b0, 1'b0, 1'b0);
      popCompare();
      applyStimulus(1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
      pushExpect("run_12_34", 1, 8'h12, 8'h34, 1'b1, 1'b0, 1'b0);
      popCompare();
      #2 rst_n = 1'b0;
      pushExpect("async_reset_now", 1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
      #1 popCompare();
      @(negedge clk_in);
      pushExpect("reset_hold", 1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
      popCompare();
      rst_n = 1'b1;
      @(negedge clk_in);

      // Tick latency and single decrement per slow_clk rise
      applyStimulus(1, 1'b1, 8'h00, 8'h03, 1'b0, 1'b0);
      applyStimulus(1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
      slow_clk = 1'b1;
      pushExpect("lat_edge1", 1, 8'h00, 8'h03, 1'b1, 1'b0, 1'b0);
      pushExpect("lat_edge2", 1, 8'h00, 8'h03, 1'b1, 1'b0, 1'b0);
      pushExpect("lat_edge3", 1, 8'h00, 8'h02, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_in);
         popCompare();
      end
      pushExpect("lat_hold_high", 1, 8'h00, 8'h02, 1'b1, 1'b0, 1'b0);
      repeat (7) @(negedge clk_in);
      popCompare();
      slow_clk = 1'b0;
      repeat (3) @(negedge clk_in);

      // Borrow chain
      applyStimulus(1, 1'b1, 8'h10, 8'h00, 1'b0, 1'b0);
      applyStimulus(1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
      pushExpect("borrow_10_00", 1, 8'h09, 8'h59, 1'b1, 1'b0, 1'b0);
      tickSlow(1);
      popCompare();
      applyStimulus(1, 1'b1, 8'h00, 8'h10, 1'b0, 1'b0);
      applyStimulus(1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
      pushExpect("borrow_00_10", 1, 8'h00, 8'h09, 1'b1, 1'b0, 1'b0);
      tickSlow(1);
      popCompare();

      // Expiry
      applyStimulus(1, 1'b1, 8'h00, 8'h02, 1'b0, 1'b0);
      applyStimulus(1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
      pushExpect("expire_first_step", 1, 8'h00, 8'h01, 1'b1, 1'b0, 1'b0);
      tickSlow(1);
      popCompare();
      pulses    = 0;
      seen_done = 0;
      slow_clk  = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk_in);
         if (i == 4) slow_clk = 1'b0;
         if (bus1.done_pulse === 1'b1) pulses++;
         if (bus1.done === 1'b1) seen_done = 1;
      end
      checkOutput("expire_done_seen", seen_done, 32'd1);
      checkOutput("expire_pulse_count", pulses, 32'd1);
      pushExpect("expire_final", 1, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
      popCompare();
      tickSlow(1);
      applyStimulus(1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
      pushExpect("done_sticky", 1, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
      popCompare();

      // Pause coincident with a step, then resume, then load beating start
      applyStimulus(1, 1'b1, 8'h00, 8'h05, 1'b0, 1'b0);
      pushExpect("load_from_done", 1, 8'h00, 8'h05, 1'b0, 1'b0, 1'b0);
      popCompare();
      applyStimulus(1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
      slow_clk = 1'b1;
      @(negedge clk_in);
      @(negedge clk_in);
      bus1.pause = 1'b1;
      @(negedge clk_in);
      bus1.pause = 1'b0;
      pushExpect("pause_beats_step", 1, 8'h00, 8'h05, 1'b0, 1'b0, 1'b0);
      popCompare();
      slow_clk = 1'b0;
      repeat (3) @(negedge clk_in);
      applyStimulus(1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1);
      pushExpect("start_beats_pause", 1, 8'h00, 8'h05, 1'b1, 1'b0, 1'b0);
      popCompare();
      applyStimulus(1, 1'b1, 8'h00, 8'h00, 1'b1, 1'b0);
      pushExpect("load_beats_start", 1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
      popCompare();
      applyStimulus(1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
      pushExpect("start_at_zero", 1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
      popCompare();

      // Clamp and prescaled stepping surviving a pause
      applyStimulus(4, 1'b1, 8'hA7, 8'h7C, 1'b0, 1'b0);
      pushExpect("clamp_load", 4, 8'h97, 8'h59, 1'b0, 1'b0, 1'b0);
      popCompare();
      applyStimulus(4, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
      tickSlow(4);
      tickSlow(4);
      pushExpect("presc_two_ticks", 4, 8'h97, 8'h59, 1'b1, 1'b0, 1'b0);
      popCompare();
      applyStimulus(4, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
      pushExpect("presc_paused", 4, 8'h97, 8'h59, 1'b0, 1'b0, 1'b0);
      popCompare();
      applyStimulus(4, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
      tickSlow(4);
      pushExpect("presc_three_ticks", 4, 8'h97, 8'h59, 1'b1, 1'b0, 1'b0);
      popCompare();
      tickSlow(4);
      pushExpect("presc_four_ticks", 4, 8'h97, 8'h58, 1'b1, 1'b0, 1'b0);
      popCompare();

      $display("== %0d vectors applied, %0d miscompares ==", vector_count, miscompare_count);
      $finish;
   end

endmodule
